ray_point_gen: RTL and testbench
================================

Name: ray_point_gen

Overview:
- Pipelined ray-evaluation unit: computes P = O + t·D per lane (x,y,z) from a ray origin O, unit direction D and march distance t.
- Inverse direction to the vector normaliser: the normaliser turns a point into a direction; this block turns direction plus distance back into a point.
- Sits between the march-step controller (supplies t from the SDF result) and the SDF evaluator (consumes P).
- Adds valid/ready handshaking with credit-based flow control, because FpAdd cannot stall.

Parameters:
- FP_W, 27, float width {sign[26], exp[25:18], mant[17:0]}, bias 127.
- ADD_LAT, 2, FpAdd pipeline latency in cycles. FpMul is combinational.
- FIFO_DEPTH, 8, output FIFO entries; must be >= ADD_LAT+2 (elaboration-time check).
- TAG_W, 10, width of the sideband tag (pixel/ray id) carried alongside the data.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_valid  in  1  input beat valid
- o_ready  out  1  input beat accepted when i_valid && o_ready at a rising edge
- i_dir_x/i_dir_y/i_dir_z  in  FP_W each  unit direction D
- i_t  in  FP_W  march distance t
- i_org_x/i_org_y/i_org_z  in  FP_W each  origin O
- i_tag  in  TAG_W  sideband tag
- o_valid  out  1  output beat valid
- i_ready  in  1  downstream ready
- o_px/o_py/o_pz  out  FP_W each  result point P
- o_tag  out  TAG_W  tag of the result

Behaviour:
- Reset (i_rst high at an edge):
  - clears the valid shift register and the FIFO pointers/count; datapath registers are not cleared.
  - During reset and the cycle after: o_valid=0, o_px/o_py/o_pz=0, o_tag=0.
  - o_ready=0 while i_rst is high, 1 from the first cycle after reset deasserts.
- Stage S0: on accept, register D, t, O and the tag; set v0=1, otherwise v0=0.
- Stage S1: FpMul(D_lane, t) per lane. Register the product, O_lane and the tag; v1<=v0.
- Stage S2..S(ADD_LAT+1): FpAdd(prod, O_lane).
  - The tag travels through a matching ADD_LAT-deep shift register.
  - v shifts alongside.
- The pipeline never stalls. A beat whose v is set on exit is written to the FIFO at that edge.
- Latency: with the FIFO empty, o_valid rises ADD_LAT+1 cycles (3 at default) after the accepting edge.
- Throughput: 1 beat/cycle sustained when i_ready is held high.
- Credit rule:
  - inflight = popcount of pipeline valid bits.
  - o_ready = (fifo_count + inflight) < FIFO_DEPTH, computed only from registered state; no combinational path i_ready->o_ready.
- FIFO:
  - o_valid = (count != 0). Outputs show the head entry.
  - Pop on o_valid && i_ready.
  - Push and pop in the same cycle leave count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - Overflow is impossible by the credit rule; an assertion flags a push when count == FIFO_DEPTH.
- Output hold: while o_valid && !i_ready, o_px/o_py/o_pz/o_tag are held stable.
- Order: results leave in acceptance order (strict FIFO).
- i_valid with o_ready=0: no accept, no state change. Upstream must hold its data.
- Reset mid-operation: in-flight and buffered beats are discarded; no partial output.
- Arithmetic: no special handling of zero/denormal beyond what FpMul/FpAdd do. A t of 0 yields P = O.

Optional Feature:
- Macro: RAYPT_PERF_CNT_EN.
- Defined:
  - adds output o_stall_cnt [15:0], which counts cycles with i_valid && !o_ready.
  - adds output o_bp_cnt [15:0], which counts cycles with o_valid && !i_ready.
  - Both saturate at 16'hFFFF and clear on i_rst.
- Undefined: the ports and counters are absent. Functional behaviour is otherwise identical.

Decomposition:
- Shared package raymarch_pkg:
  - FP_W
  - FP_ZERO = 27'h0000000, FP_ONE = 27'h1FC0000, FP_TWO = 27'h2000000, FP_HALF = 27'h1F80000, FP_THREE = 27'h2020000
  - ADD_LAT
  - packed struct type vec3_fp_t {x,y,z}
- Sub-module raypt_fifo: synchronous FIFO (width 3·FP_W+TAG_W, depth FIFO_DEPTH) that exposes count.
- FpMul and FpAdd are instantiated directly, 3 of each.

Test Plan:
- Single beat: D=(1.0,0,0), t=2.0, O=(1.0,0.5,0), tag=5, i_ready=1 -> 3 cycles after accept, o_valid=1 with P=(27'h2020000, 27'h1F80000, 0) and o_tag=5, for exactly one cycle.
- Streaming: 20 back-to-back beats with tags 0..19, t=FP_ONE, O=0, i_ready=1 -> o_ready never drops; outputs arrive in order on 20 consecutive cycles.
- Backpressure:
  - i_ready=0 while 12 beats are offered -> o_ready falls after exactly FIFO_DEPTH beats are accepted; the FIFO reaches count 8 with no loss.
  - Release i_ready -> 8 beats drain in order, then o_ready reasserts.
- Simultaneous push/pop: FIFO at count 4, i_ready=1, one accept per cycle -> count stays 4 and no beat is duplicated or dropped.
- Reset mid-stream: assert i_rst with 3 in-flight and 2 buffered beats -> next cycle o_valid=0 and outputs 0; after release, the first new beat emerges with correct latency and no stale data.
- RAYPT_PERF_CNT_EN: hold i_ready=0 for 70000 cycles with i_valid=1 -> o_bp_cnt and o_stall_cnt saturate at 16'hFFFF; i_rst clears both to 0.

Source files
------------

// File: rtl/raymarch_pkg.sv
// Shared raymarch types and constants.
// 27-bit float: sign[26], exp[25:18], mant[17:0], bias 127.
package raymarch_pkg;

    localparam int FP_W    = 27;
    localparam int ADD_LAT = 2;

    localparam logic [FP_W-1:0] FP_ZERO  = 27'h0000000;
    localparam logic [FP_W-1:0] FP_ONE   = 27'h1FC0000;
    localparam logic [FP_W-1:0] FP_TWO   = 27'h2000000;
    localparam logic [FP_W-1:0] FP_HALF  = 27'h1F80000;
    localparam logic [FP_W-1:0] FP_THREE = 27'h2020000;

    typedef struct packed {
        logic [FP_W-1:0] x;
        logic [FP_W-1:0] y;
        logic [FP_W-1:0] z;
    } vec3_fp_t;

endpackage

// File: rtl/FpAdd.sv
// Pipelined float add, LAT cycles, truncating, no stall.
// Inputs registered first; result then delayed by LAT-1 stages.
module FpAdd
    import raymarch_pkg::*;
#(
    parameter int LAT = ADD_LAT
) (
    input  logic            i_clk,
    input  logic [FP_W-1:0] i_a,
    input  logic [FP_W-1:0] i_b,
    output logic [FP_W-1:0] o_y
);

    logic [FP_W-1:0] a_q;
    logic [FP_W-1:0] b_q;
    logic [FP_W-1:0] big;
    logic [FP_W-1:0] sml;
    logic [FP_W-1:0] res;
    logic [7:0]      e_big;
    logic [7:0]      e_sml;
    logic [7:0]      e_diff;
    logic [21:0]     m_big;
    logic [21:0]     m_sml;
    logic [21:0]     m_sh;
    logic [22:0]     acc;
    logic [17:0]     m_norm;
    logic [4:0]      lz;
    logic            found;
    logic [9:0]      e_res;

    // operand capture stage
    always_ff @(posedge i_clk) begin
        a_q <= i_a;
        b_q <= i_b;
    end

    // align smaller operand, add/sub, renormalise
    always_comb begin
        if (a_q[25:0] >= b_q[25:0]) begin
            big = a_q;
            sml = b_q;
        end else begin
            big = b_q;
            sml = a_q;
        end
        e_big  = big[25:18];
        e_sml  = sml[25:18];
        e_diff = e_big - e_sml;
        m_big  = (e_big == 8'd0) ? '0 : {1'b1, big[17:0], 3'b000};
        m_sml  = (e_sml == 8'd0) ? '0 : {1'b1, sml[17:0], 3'b000};
        m_sh   = (e_diff > 8'd21) ? '0 : (m_sml >> e_diff);
        if (big[26] == sml[26])
            acc = {1'b0, m_big} + {1'b0, m_sh};
        else
            acc = {1'b0, m_big} - {1'b0, m_sh};
        lz    = '0;
        found = 1'b0;
        for (int i = 21; i >= 0; i--) begin
            if (!found && acc[i]) begin
                lz    = 5'(21 - i);
                found = 1'b1;
            end
        end
        m_norm = 18'((acc[21:0] << lz) >> 3);
        e_res  = '0;
        res    = '0;
        if (acc[22]) begin
            e_res = {2'b00, e_big} + 10'd1;
            if (e_res >= 10'd255)
                res = {big[26], 8'hFF, 18'h0};
            else
                res = {big[26], e_res[7:0], acc[21:4]};
        end else if (found) begin
            e_res = {2'b00, e_big} - {5'b0, lz};
            if (!e_res[9] && e_res != 10'd0)
                res = {big[26], e_res[7:0], m_norm};
        end
    end

    if (LAT <= 1) begin : g_l1
        assign o_y = res;
    end else begin : g_ln
        logic [FP_W-1:0] pipe [LAT-1];

        // result delay line
        always_ff @(posedge i_clk) begin
            pipe[0] <= res;
            for (int i = 1; i < LAT - 1; i++)
                pipe[i] <= pipe[i-1];
        end

        assign o_y = pipe[LAT-2];
    end

endmodule

// File: rtl/FpMul.sv
// Combinational float multiply, truncating.
// Zero/denormal inputs or underflow give +0; overflow gives inf.
module FpMul
    import raymarch_pkg::*;
(
    input  logic [FP_W-1:0] i_a,
    input  logic [FP_W-1:0] i_b,
    output logic [FP_W-1:0] o_y
);

    logic [18:0] ma;
    logic [18:0] mb;
    logic [19:0] prod_hi;
    logic [9:0]  e_sum;
    logic [17:0] mant;
    logic        sgn;

    // multiply mantissas, add exponents, normalise by one bit at most
    always_comb begin
        sgn     = i_a[26] ^ i_b[26];
        ma      = {1'b1, i_a[17:0]};
        mb      = {1'b1, i_b[17:0]};
        prod_hi = 20'(({19'b0, ma} * {19'b0, mb}) >> 18);
        e_sum   = {2'b00, i_a[25:18]} + {2'b00, i_b[25:18]} - 10'd127;
        mant    = prod_hi[17:0];
        if (prod_hi[19]) begin
            mant  = prod_hi[18:1];
            e_sum = e_sum + 10'd1;
        end
        if (i_a[25:18] == 8'd0 || i_b[25:18] == 8'd0 ||
            e_sum[9] || e_sum == 10'd0)
            o_y = '0;
        else if (e_sum >= 10'd255)
            o_y = {sgn, 8'hFF, 18'h0};
        else
            o_y = {sgn, e_sum[7:0], mant};
    end

endmodule

// File: rtl/raypt_fifo.sv
// Output FIFO for ray_point_gen; exposes occupancy count.
// Pointers wrap modulo DEPTH, so DEPTH need not be a power of two.
module raypt_fifo #(
    parameter int W     = 91,
    parameter int DEPTH = 8
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_push,
    input  logic [W-1:0]                 i_data,
    input  logic                         i_pop,
    output logic [W-1:0]                 o_data,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign do_pop  = i_pop && (count != '0);
    assign o_data  = mem[rd_ptr];
    assign o_count = count;

    // storage write, no reset needed
    always_ff @(posedge i_clk) begin
        if (i_push)
            mem[wr_ptr] <= i_data;
    end

    // pointers and occupancy
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (i_push)
                wr_ptr <= nxt(wr_ptr);
            if (do_pop)
                rd_ptr <= nxt(rd_ptr);
            unique case (1'b1)
                i_push && !do_pop: count <= count + CW'(1);
                !i_push && do_pop: count <= count - CW'(1);
                default: ;
            endcase
        end
    end

    // credit logic upstream must keep us from overflowing
    always_ff @(posedge i_clk) begin
        if (!i_rst && i_push)
            assert (count != CW'(DEPTH));
    end

endmodule

// File: rtl/ray_point_gen.sv
// Ray evaluation P = O + t*D, credit flow control, output FIFO.
// Optional RAYPT_PERF_CNT_EN adds stall/backpressure counters.
module ray_point_gen
    import raymarch_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int TAG_W      = 10
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [FP_W-1:0]  i_dir_x,
    input  logic [FP_W-1:0]  i_dir_y,
    input  logic [FP_W-1:0]  i_dir_z,
    input  logic [FP_W-1:0]  i_t,
    input  logic [FP_W-1:0]  i_org_x,
    input  logic [FP_W-1:0]  i_org_y,
    input  logic [FP_W-1:0]  i_org_z,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [FP_W-1:0]  o_px,
    output logic [FP_W-1:0]  o_py,
    output logic [FP_W-1:0]  o_pz,
    output logic [TAG_W-1:0] o_tag
`ifdef RAYPT_PERF_CNT_EN
    ,
    output logic [15:0]      o_stall_cnt,
    output logic [15:0]      o_bp_cnt
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int DW = 3 * FP_W + TAG_W;

    if (FIFO_DEPTH < ADD_LAT + 2) begin : g_depth_chk
        $error("FIFO_DEPTH must be at least ADD_LAT+2");
    end

    logic               accept;
    logic               v0;
    vec3_fp_t           d0;
    vec3_fp_t           o0;
    logic [FP_W-1:0]    t0;
    logic [TAG_W-1:0]   tag0;
    logic [FP_W-1:0]    prod_x;
    logic [FP_W-1:0]    prod_y;
    logic [FP_W-1:0]    prod_z;
    logic [FP_W-1:0]    sum_x;
    logic [FP_W-1:0]    sum_y;
    logic [FP_W-1:0]    sum_z;
    logic [ADD_LAT-1:0] v_sr;
    logic [TAG_W-1:0]   tag_sr [ADD_LAT];
    logic [CW-1:0]      fifo_count;
    logic [CW:0]        inflight;
    logic [CW:0]        used;
    logic               push;
    logic               pop;
    logic [DW-1:0]      wr_data;
    logic [DW-1:0]      rd_data;
    logic [FP_W-1:0]    head_x;
    logic [FP_W-1:0]    head_y;
    logic [FP_W-1:0]    head_z;
    logic [TAG_W-1:0]   head_tag;

    // beats still travelling towards the FIFO
    always_comb begin
        inflight = {{CW{1'b0}}, v0};
        for (int i = 0; i < ADD_LAT; i++)
            inflight = inflight + {{CW{1'b0}}, v_sr[i]};
    end

    assign used    = {1'b0, fifo_count} + inflight;
    assign o_ready = !i_rst && (used < (CW+1)'(FIFO_DEPTH));
    assign accept  = i_valid && o_ready;

    // S0 operand capture
    always_ff @(posedge i_clk) begin
        if (accept) begin
            d0   <= {i_dir_x, i_dir_y, i_dir_z};
            o0   <= {i_org_x, i_org_y, i_org_z};
            t0   <= i_t;
            tag0 <= i_tag;
        end
    end

    // valid chain alongside the datapath
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            v0   <= 1'b0;
            v_sr <= '0;
        end else begin
            v0      <= accept;
            v_sr[0] <= v0;
            for (int i = 1; i < ADD_LAT; i++)
                v_sr[i] <= v_sr[i-1];
        end
    end

    // tag delay matching the adder latency
    always_ff @(posedge i_clk) begin
        tag_sr[0] <= tag0;
        for (int i = 1; i < ADD_LAT; i++)
            tag_sr[i] <= tag_sr[i-1];
    end

    FpMul u_mul_x (.i_a(d0.x), .i_b(t0), .o_y(prod_x));
    FpMul u_mul_y (.i_a(d0.y), .i_b(t0), .o_y(prod_y));
    FpMul u_mul_z (.i_a(d0.z), .i_b(t0), .o_y(prod_z));

    FpAdd #(.LAT(ADD_LAT)) u_add_x (
        .i_clk (i_clk),
        .i_a   (prod_x),
        .i_b   (o0.x),
        .o_y   (sum_x)
    );
    FpAdd #(.LAT(ADD_LAT)) u_add_y (
        .i_clk (i_clk),
        .i_a   (prod_y),
        .i_b   (o0.y),
        .o_y   (sum_y)
    );
    FpAdd #(.LAT(ADD_LAT)) u_add_z (
        .i_clk (i_clk),
        .i_a   (prod_z),
        .i_b   (o0.z),
        .o_y   (sum_z)
    );

    assign push    = v_sr[ADD_LAT-1];
    assign wr_data = {sum_x, sum_y, sum_z, tag_sr[ADD_LAT-1]};

    raypt_fifo #(
        .W     (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (push),
        .i_data  (wr_data),
        .i_pop   (pop),
        .o_data  (rd_data),
        .o_count (fifo_count)
    );

    assign {head_x, head_y, head_z, head_tag} = rd_data;

    assign o_valid = !i_rst && (fifo_count != '0);
    assign pop     = o_valid && i_ready;
    assign o_px    = o_valid ? head_x : '0;
    assign o_py    = o_valid ? head_y : '0;
    assign o_pz    = o_valid ? head_z : '0;
    assign o_tag   = o_valid ? head_tag : '0;

`ifdef RAYPT_PERF_CNT_EN
    // saturating stall and backpressure counters
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_stall_cnt <= '0;
            o_bp_cnt    <= '0;
        end else begin
            if (i_valid && !o_ready && o_stall_cnt != 16'hFFFF)
                o_stall_cnt <= o_stall_cnt + 16'd1;
            if (o_valid && !i_ready && o_bp_cnt != 16'hFFFF)
                o_bp_cnt <= o_bp_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ray_point_gen.sv
// Directed bench for ray_point_gen.
// Define RAYPT_PERF_CNT_EN to also exercise the perf counters.
module tb_ray_point_gen;
    import raymarch_pkg::*;

    localparam int TW = 10;
    localparam logic [FP_W-1:0] NEG_ONE  = 27'h5FC0000;
    localparam logic [FP_W-1:0] NEG_HALF = 27'h5F80000;
    localparam logic [FP_W-1:0] TWO_HALF = 27'h2010000;

    logic            i_clk = 1'b0;
    logic            i_rst;
    logic            i_valid;
    logic            o_ready;
    logic [FP_W-1:0] i_dir_x, i_dir_y, i_dir_z, i_t;
    logic [FP_W-1:0] i_org_x, i_org_y, i_org_z;
    logic [TW-1:0]   i_tag;
    logic            o_valid;
    logic            i_ready;
    logic [FP_W-1:0] o_px, o_py, o_pz;
    logic [TW-1:0]   o_tag;
`ifdef RAYPT_PERF_CNT_EN
    logic [15:0]     o_stall_cnt;
    logic [15:0]     o_bp_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int acc;

    always #5 i_clk = ~i_clk;

    ray_point_gen #(.FIFO_DEPTH(8), .TAG_W(TW)) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_dir_x (i_dir_x),
        .i_dir_y (i_dir_y),
        .i_dir_z (i_dir_z),
        .i_t     (i_t),
        .i_org_x (i_org_x),
        .i_org_y (i_org_y),
        .i_org_z (i_org_z),
        .i_tag   (i_tag),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_px    (o_px),
        .o_py    (o_py),
        .o_pz    (o_pz),
        .o_tag   (o_tag)
`ifdef RAYPT_PERF_CNT_EN
        ,
        .o_stall_cnt (o_stall_cnt),
        .o_bp_cnt    (o_bp_cnt)
`endif
    );

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_beat(
        input logic [FP_W-1:0] dx, dy, dz, t, ox, oy, oz,
        input int tg
    );
        i_dir_x = dx;
        i_dir_y = dy;
        i_dir_z = dz;
        i_t     = t;
        i_org_x = ox;
        i_org_y = oy;
        i_org_z = oz;
        i_tag   = TW'(tg);
        i_valid = 1'b1;
    endtask

    initial begin
        i_rst   = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b1;
        set_beat(FP_ZERO, FP_ZERO, FP_ZERO, FP_ZERO,
                 FP_ZERO, FP_ZERO, FP_ZERO, 0);
        i_valid = 1'b0;
        repeat (3) step();

        // reset state
        chk("rst_ready", 32'(o_ready), 32'd0);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_px", 32'(o_px), 32'd0);
        chk("rst_tag", 32'(o_tag), 32'd0);
        i_rst = 1'b0;
        step();
        chk("post_rst_valid", 32'(o_valid), 32'd0);
        chk("post_rst_pz", 32'(o_pz), 32'd0);
        chk("post_rst_ready", 32'(o_ready), 32'd1);

        // single beat, latency 3, one cycle of valid
        set_beat(FP_ONE, FP_ZERO, FP_ZERO, FP_TWO,
                 FP_ONE, FP_HALF, FP_ZERO, 5);
        chk("single_ready", 32'(o_ready), 32'd1);
        step();
        i_valid = 1'b0;
        step();
        chk("single_lat1", 32'(o_valid), 32'd0);
        step();
        chk("single_lat2", 32'(o_valid), 32'd0);
        step();
        chk("single_valid", 32'(o_valid), 32'd1);
        chk("single_px", 32'(o_px), 32'(FP_THREE));
        chk("single_py", 32'(o_py), 32'(FP_HALF));
        chk("single_pz", 32'(o_pz), 32'd0);
        chk("single_tag", 32'(o_tag), 32'd5);
        step();
        chk("single_once", 32'(o_valid), 32'd0);

        // streaming, 20 back-to-back beats
        for (int i = 0; i < 23; i++) begin
            if (i < 20) begin
                set_beat(FP_ONE, FP_ZERO, FP_ZERO, FP_ONE,
                         FP_ZERO, FP_ZERO, FP_ZERO, i);
                chk("stream_ready", 32'(o_ready), 32'd1);
            end else begin
                i_valid = 1'b0;
            end
            step();
            if (i >= 3) begin
                chk("stream_valid", 32'(o_valid), 32'd1);
                chk("stream_tag", 32'(o_tag), 32'(i - 3));
                chk("stream_px", 32'(o_px), 32'(FP_ONE));
            end
        end
        step();
        chk("stream_end", 32'(o_valid), 32'd0);

        // backpressure: 12 offers, exactly 8 accepted
        i_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 12; c++) begin
            set_beat(FP_ONE, FP_ZERO, FP_ZERO, FP_ONE,
                     FP_ZERO, FP_ZERO, FP_ZERO, 100 + acc);
            chk("bp_ready", 32'(o_ready), 32'(acc < 8));
            if (o_ready)
                acc++;
            step();
        end
        i_valid = 1'b0;
        chk("bp_accepted", 32'(acc), 32'd8);
        repeat (3) step();
        chk("bp_count", 32'(dut.fifo_count), 32'd8);
        chk("bp_full_ready", 32'(o_ready), 32'd0);
        chk("bp_head", 32'(o_tag), 32'd100);
        step();
        chk("bp_hold_tag", 32'(o_tag), 32'd100);
        chk("bp_hold_px", 32'(o_px), 32'(FP_ONE));
        i_ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            chk("drain_valid", 32'(o_valid), 32'd1);
            chk("drain_tag", 32'(o_tag), 32'(100 + j));
            step();
        end
        chk("drain_empty", 32'(o_valid), 32'd0);
        chk("drain_ready", 32'(o_ready), 32'd1);

        // simultaneous push/pop around count 4
        i_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            set_beat(FP_ONE, FP_ZERO, FP_ZERO, FP_ONE,
                     FP_ZERO, FP_ZERO, FP_ZERO, 200 + k);
            step();
        end
        i_valid = 1'b0;
        repeat (3) step();
        chk("pp_fill", 32'(dut.fifo_count), 32'd4);
        for (int i = 0; i < 10; i++) begin
            if (i < 6)
                set_beat(FP_ONE, FP_ZERO, FP_ZERO, FP_ONE,
                         FP_ZERO, FP_ZERO, FP_ZERO, 204 + i);
            else
                i_valid = 1'b0;
            i_ready = (i >= 3);
            step();
            chk("pp_count", 32'(dut.fifo_count),
                (i <= 8) ? 32'd4 : 32'd3);
            chk("pp_head", 32'(o_tag),
                (i >= 3) ? 32'(198 + i) : 32'd200);
        end
        for (int j = 0; j < 3; j++) begin
            chk("pp_drain_valid", 32'(o_valid), 32'd1);
            chk("pp_drain_tag", 32'(o_tag), 32'(207 + j));
            step();
        end
        chk("pp_empty", 32'(o_valid), 32'd0);

        // reset with 2 buffered and 3 in flight
        i_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            set_beat(FP_ONE, FP_ONE, FP_ONE, FP_ONE,
                     FP_ONE, FP_ONE, FP_ONE, 300 + k);
            step();
        end
        i_valid = 1'b0;
        repeat (3) step();
        for (int k = 2; k < 5; k++) begin
            set_beat(FP_ONE, FP_ONE, FP_ONE, FP_ONE,
                     FP_ONE, FP_ONE, FP_ONE, 300 + k);
            step();
        end
        i_valid = 1'b0;
        chk("mid_buffered", 32'(dut.fifo_count), 32'd2);
        i_rst = 1'b1;
        step();
        chk("mid_rst_valid", 32'(o_valid), 32'd0);
        chk("mid_rst_px", 32'(o_px), 32'd0);
        chk("mid_rst_tag", 32'(o_tag), 32'd0);
        chk("mid_rst_ready", 32'(o_ready), 32'd0);
        i_rst   = 1'b0;
        i_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("mid_no_stale", 32'(o_valid), 32'd0);
            chk("mid_no_stale_tag", 32'(o_tag), 32'd0);
        end

        // subtraction case: 1*0.5 + (-1) = -0.5
        set_beat(FP_ONE, FP_ZERO, FP_ZERO, FP_HALF,
                 NEG_ONE, FP_ZERO, FP_ZERO, 400);
        step();
        i_valid = 1'b0;
        step();
        step();
        chk("new_lat", 32'(o_valid), 32'd0);
        step();
        chk("new_valid", 32'(o_valid), 32'd1);
        chk("new_px", 32'(o_px), 32'(NEG_HALF));
        chk("new_tag", 32'(o_tag), 32'd400);

        // t = 0 gives P = O, then 0.5*3 + 1 = 2.5
        set_beat(FP_ONE, FP_ONE, FP_ONE, FP_ZERO,
                 FP_THREE, FP_TWO, FP_HALF, 401);
        step();
        set_beat(FP_HALF, FP_ZERO, FP_ONE, FP_THREE,
                 FP_ONE, FP_ZERO, FP_ZERO, 402);
        step();
        i_valid = 1'b0;
        step();
        step();
        chk("t0_tag", 32'(o_tag), 32'd401);
        chk("t0_px", 32'(o_px), 32'(FP_THREE));
        chk("t0_py", 32'(o_py), 32'(FP_TWO));
        chk("t0_pz", 32'(o_pz), 32'(FP_HALF));
        step();
        chk("mant_tag", 32'(o_tag), 32'd402);
        chk("mant_px", 32'(o_px), 32'(TWO_HALF));
        chk("mant_py", 32'(o_py), 32'd0);
        chk("mant_pz", 32'(o_pz), 32'(FP_THREE));
        step();
        chk("mant_end", 32'(o_valid), 32'd0);

`ifdef RAYPT_PERF_CNT_EN
        // counters saturate, reset clears them
        i_ready = 1'b0;
        set_beat(FP_ONE, FP_ZERO, FP_ZERO, FP_ONE,
                 FP_ZERO, FP_ZERO, FP_ZERO, 500);
        repeat (70000) @(posedge i_clk);
        #1;
        chk("perf_stall_sat", 32'(o_stall_cnt), 32'h0000FFFF);
        chk("perf_bp_sat", 32'(o_bp_cnt), 32'h0000FFFF);
        i_valid = 1'b0;
        i_rst   = 1'b1;
        step();
        chk("perf_stall_clr", 32'(o_stall_cnt), 32'd0);
        chk("perf_bp_clr", 32'(o_bp_cnt), 32'd0);
        i_rst = 1'b0;
        step();
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
